// File: rtl/lut_layer_scheduler_if.sv
// lut_layer_scheduler_if: input-vector, LUT-port and output-vector handshakes of one layer scheduler
// master = scheduler side: drives in_ready, lut_sel/lut_addr/lut_en, out_valid/out_data
// slave  = environment side: drives in_valid/in_data, lut_data, out_ready
interface lut_layer_scheduler_if #(
  parameter int NUM_NEURONS = 8,
  parameter int IN_W = 6,
  parameter int OUT_W = 2
);
  localparam int SEL_W = $clog2(NUM_NEURONS);
  logic in_valid;
  logic in_ready;
  logic [NUM_NEURONS*IN_W-1:0] in_data;
  logic [SEL_W-1:0] lut_sel;
  logic [IN_W-1:0] lut_addr;
  logic lut_en;
  logic [OUT_W-1:0] lut_data;
  logic out_valid;
  logic out_ready;
  logic [NUM_NEURONS*OUT_W-1:0] out_data;
  modport master (
    input in_valid, in_data, lut_data, out_ready,
    output in_ready, lut_sel, lut_addr, lut_en, out_valid, out_data
  );
  modport slave (
    output in_valid, in_data, lut_data, out_ready,
    input in_ready, lut_sel, lut_addr, lut_en, out_valid, out_data
  );
endinterface

// File: rtl/lut_layer_scheduler.sv
// lut_layer_scheduler: time-multiplexes one shared neuron-LUT port across all neurons of a layer
// clk, rst_n (async active-low); bus (master): in_* capture, lut_* issue one neuron per cycle,
// out_* gathered result vector; busy = not idle.
// LUT_SCHED_PERF_EN adds saturating perf_vectors (out handshakes) and perf_stall (out_valid & !out_ready).
module lut_layer_scheduler #(
  parameter int NUM_NEURONS = 8,
  parameter int IN_W = 6,
  parameter int OUT_W = 2,
  parameter int LUT_LAT = 0
) (
  input  logic clk,
  input  logic rst_n,
  lut_layer_scheduler_if.master bus,
`ifdef LUT_SCHED_PERF_EN
  output logic busy,
  output logic [31:0] perf_vectors,
  output logic [31:0] perf_stall
`else
  output logic busy
`endif
);
  localparam int SEL_W = $clog2(NUM_NEURONS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_NEURONS - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [NUM_NEURONS*IN_W-1:0] cap;
  logic [SEL_W-1:0] iss_cnt, col_cnt;
  logic accept, col, col_last, iss_last;
  assign bus.in_ready = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign accept = bus.in_valid & bus.in_ready;
  assign iss_last = iss_cnt == LAST;
  assign col_last = col & (col_cnt == LAST);
  // col marks the cycle whose lut_data belongs to the next slot in order
  if (LUT_LAT == 0) begin : g_comb
    assign col = bus.lut_en;
  end else begin : g_pipe
    logic [LUT_LAT-1:0] tag;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) tag <= '0;
      else tag <= LUT_LAT'({tag, bus.lut_en});
    assign col = tag[LUT_LAT-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = accept ? ISSUE : IDLE;
      ISSUE:   state_nx = !iss_last ? ISSUE : (LUT_LAT == 0) ? DONE : DRAIN;
      DRAIN:   state_nx = col_last ? DONE : DRAIN;
      DONE:    state_nx = !bus.out_ready ? DONE : accept ? ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
    bus.lut_en = state == ISSUE;
    bus.lut_sel = bus.lut_en ? iss_cnt : '0;
    bus.lut_addr = bus.lut_en ? cap[iss_cnt*IN_W +: IN_W] : '0;
    bus.out_valid = state == DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cap <= '0;
      iss_cnt <= '0;
      col_cnt <= '0;
      bus.out_data <= '0;
    end else begin
      if (accept) cap <= bus.in_data;
      iss_cnt <= accept ? '0 : (state == ISSUE) ? (iss_last ? '0 : iss_cnt + 1'b1) : iss_cnt;
      col_cnt <= accept ? '0 : col ? (col_last ? '0 : col_cnt + 1'b1) : col_cnt;
      if (col) bus.out_data[col_cnt*OUT_W +: OUT_W] <= bus.lut_data;
    end
`ifdef LUT_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_vectors <= '0;
      perf_stall <= '0;
    end else begin
      if (bus.out_valid & bus.out_ready & ~&perf_vectors) perf_vectors <= perf_vectors + 32'd1;
      if (bus.out_valid & !bus.out_ready & ~&perf_stall) perf_stall <= perf_stall + 32'd1;
    end
`endif
endmodule
